// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   General-purpose CPU register file with 2**ADDR_WIDTH words of
//   DATA_WIDTH bits. It has two combinational read ports and one write port
//   that updates on the falling clock edge. Register 0 is hardwired to zero
//   and has no storage behind it.
//
//   Writes land on the falling edge. A value written back in one cycle can
//   therefore be read by decode during the second half of that same cycle.
//
// Ports
//   clock      in   1           single clock; all state changes on negedge
//   reset      in   1           synchronous, active-high; clears all registers
//   ReadReg1   in   ADDR_WIDTH  read port 1 address
//   ReadReg2   in   ADDR_WIDTH  read port 2 address
//   writeReg   in   ADDR_WIDTH  write port address
//   writeData  in   DATA_WIDTH  write port data
//   write      in   1           write enable, active-high
//   out1       out  DATA_WIDTH  contents of register ReadReg1 (combinational)
//   out2       out  DATA_WIDTH  contents of register ReadReg2 (combinational)
// ---------------------------------------------------------------------------
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  input  logic [ADDR_WIDTH-1:0] writeReg,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  write,
  output logic [DATA_WIDTH-1:0] out1,
  output logic [DATA_WIDTH-1:0] out2
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Storage exists only for registers 1..DEPTH-1.
  logic [DATA_WIDTH-1:0] regs_reg [1:DEPTH-1];

  // Reset takes priority over a write in the same edge. A write to
  // address 0 matches no entry, so it drops out naturally.
  always_ff @(negedge clock) begin
    for (int i = 1; i < DEPTH; i++) begin
      if (reset) begin
        regs_reg[i] <= '0;
      end else if (write && (writeReg == ADDR_WIDTH'(i))) begin
        regs_reg[i] <= writeData;
      end
    end
  end

  // The read view covers the full address range, with slot 0 tied to
  // constant zero. This lets the read mux index it directly, with no
  // out-of-range select. Because slot 0 is a constant, reads of r0 return
  // zero even before the first reset, when the real registers are still
  // undefined.
  logic [DATA_WIDTH-1:0] rd_word [0:DEPTH-1];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rd_word
      if (gi == 0) begin : g_zero
        assign rd_word[gi] = '0;
      end else begin : g_reg
        assign rd_word[gi] = regs_reg[gi];
      end
    end
  endgenerate

  // Reads have zero latency and no write bypass. A write becomes visible
  // only once it has been stored at the falling edge.
  assign out1 = rd_word[ReadReg1];
  assign out2 = rd_word[ReadReg2];

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//   Directed self-checking bench for register_file.
//   The bench drives inputs while the clock is high or low, away from the
//   falling edge. It samples outputs 1 time unit after each falling edge,
//   or after an input change.
// ---------------------------------------------------------------------------
module tb_register_file;

  logic        clock;
  logic        reset;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic        write;
  logic [31:0] out1;
  logic [31:0] out2;

  int checks   = 0;
  int failures = 0;

  register_file #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(5)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ReadReg1 (ReadReg1),
    .ReadReg2 (ReadReg2),
    .writeReg (writeReg),
    .writeData(writeData),
    .write    (write),
    .out1     (out1),
    .out2     (out2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
    $display("check %-14s observed=%08h expected=%08h", tag, obs, exp);
  endtask

  // One write transaction, committed at the next falling edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    writeReg  = a;
    writeData = d;
    write     = 1'b1;
    @(negedge clock);
    #1;
    write = 1'b0;
    $display("write r%0d <= %08h", a, d);
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, ~b, 8'h5a, b ^ 8'hc3};
  endfunction

  initial begin
    reset     = 1'b0;
    write     = 1'b0;
    writeReg  = '0;
    writeData = '0;
    ReadReg1  = '0;
    ReadReg2  = '0;

    // Before the first reset, r0 must still read zero.
    #1;
    check("pwrup_r0_p1", out1, 32'h0);
    check("pwrup_r0_p2", out2, 32'h0);

    // Initial reset.
    reset = 1'b1;
    @(negedge clock);
    #1;
    reset = 1'b0;
    ReadReg1 = 5'd1;
    ReadReg2 = 5'd31;
    #1;
    check("rst_r1", out1, 32'h0);
    check("rst_r31", out2, 32'h0);

    // Test 1: basic writes.
    wr(5'd1,  32'haaaaaaaa);
    wr(5'd11, 32'hbbbbbbbb);
    wr(5'd31, 32'hcccccccc);
    ReadReg1 = 5'd1;
    ReadReg2 = 5'd11;
    #1;
    check("t1_r1", out1, 32'haaaaaaaa);
    check("t1_r11", out2, 32'hbbbbbbbb);

    // Test 2: a write to r0 is ignored.
    wr(5'd0, 32'hdddddddd);
    ReadReg1 = 5'd31;
    ReadReg2 = 5'd0;
    #1;
    check("t2_r31", out1, 32'hcccccccc);
    check("t2_r0", out2, 32'h0);

    // Test 3: write enable low.
    write     = 1'b0;
    writeReg  = 5'd1;
    writeData = 32'h12345678;
    @(negedge clock);
    #1;
    ReadReg1 = 5'd1;
    #1;
    check("t3_wen_off", out1, 32'haaaaaaaa);

    // Test 4: reset raised mid-cycle, together with a write to r5.
    @(posedge clock);
    #1;
    reset     = 1'b1;
    write     = 1'b1;
    writeReg  = 5'd5;
    writeData = 32'hffffffff;
    ReadReg1  = 5'd1;
    ReadReg2  = 5'd31;
    #1;
    check("t4_pre_r1", out1, 32'haaaaaaaa);
    check("t4_pre_r31", out2, 32'hcccccccc);
    @(negedge clock);
    #1;
    reset = 1'b0;
    write = 1'b0;
    ReadReg1 = 5'd1;
    ReadReg2 = 5'd5;
    #1;
    check("t4_r1", out1, 32'h0);
    check("t4_r5_prio", out2, 32'h0);
    ReadReg1 = 5'd11;
    ReadReg2 = 5'd31;
    #1;
    check("t4_r11", out1, 32'h0);
    check("t4_r31", out2, 32'h0);

    // Test 5: read-during-write timing.
    wr(5'd7, 32'h11112222);
    ReadReg1  = 5'd7;
    writeReg  = 5'd7;
    writeData = 32'h0badf00d;
    write     = 1'b1;
    #1;
    check("t5_before", out1, 32'h11112222);
    @(negedge clock);
    #1;
    write = 1'b0;
    check("t5_after", out1, 32'h0badf00d);
    ReadReg1 = 5'd0;
    #1;
    check("t5_addr_r0", out1, 32'h0);
    ReadReg1 = 5'd7;
    #1;
    check("t5_addr_r7", out1, 32'h0badf00d);

    // Test 6: dual-port same address, then a full sweep.
    wr(5'd31, 32'hcccccccc);
    ReadReg1 = 5'd31;
    ReadReg2 = 5'd31;
    #1;
    check("t6_same_p1", out1, 32'hcccccccc);
    check("t6_same_p2", out2, 32'hcccccccc);

    for (int i = 1; i < 32; i++) begin
      wr(5'(i), pat(i));
    end
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i);
      ReadReg2 = 5'(31 - i);
      #1;
      check($sformatf("sweep_p1_r%0d", i), out1, (i == 0) ? 32'h0 : pat(i));
      check($sformatf("sweep_p2_r%0d", 31 - i), out2, (i == 31) ? 32'h0 : pat(31 - i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
